// File: rtl/alu_issue_pkg.sv
// Shared opcode/funct constants and the ALU control bundle for the ALU issue stage.
// Optional skid entry in alu_issue is enabled by defining ALU_ISSUE_SKID_EN.
package alu_issue_pkg;

  localparam int unsigned ALU_W = 16;

  localparam logic [4:0] OP_ADDI   = 5'b01000;
  localparam logic [4:0] OP_SUBI   = 5'b01001;
  localparam logic [4:0] OP_XORI   = 5'b01010;
  localparam logic [4:0] OP_ANDNI  = 5'b01011;
  localparam logic [4:0] OP_ST     = 5'b10000;
  localparam logic [4:0] OP_LD     = 5'b10001;
  localparam logic [4:0] OP_SLBI   = 5'b10010;
  localparam logic [4:0] OP_STU    = 5'b10011;
  localparam logic [4:0] OP_RSHIFT = 5'b11010;
  localparam logic [4:0] OP_RARITH = 5'b11011;

  // Shift-immediate opcodes share the 101xx prefix.
  localparam logic [2:0] OP_SHIFTI_PFX = 3'b101;

  localparam logic [1:0] FUNCT_ADD  = 2'b00;
  localparam logic [1:0] FUNCT_SUB  = 2'b01;
  localparam logic [1:0] FUNCT_XOR  = 2'b10;
  localparam logic [1:0] FUNCT_ANDN = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [ALU_W-1:0] op;
    logic             cin;
    logic             inv_a;
    logic             inv_b;
    logic             sign;
  } alu_ctrl_t;

  function automatic logic [ALU_W-1:0] sext5(input logic [4:0] v);
    return {{(ALU_W-5){v[4]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side and execute-side handshake bundle of the ALU issue stage.
// slave: the issue stage; master: the surrounding pipeline.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ALU_W-1:0] in_instr;
  logic [ALU_W-1:0] in_rs_data;
  logic [ALU_W-1:0] in_rt_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  logic [ALU_W-1:0] alu_op;
  logic             alu_cin;
  logic             alu_inv_a;
  logic             alu_inv_b;
  logic             alu_sign;

  modport slave (
    input  in_valid, in_instr, in_rs_data, in_rt_data, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, alu_cin, alu_inv_a, alu_inv_b, alu_sign
  );

  modport master (
    output in_valid, in_instr, in_rs_data, in_rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, alu_cin, alu_inv_a, alu_inv_b, alu_sign
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational map from instruction word and register reads to ALU operands/controls.
module alu_ctrl_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output alu_ctrl_t         ctrl
);

  logic [4:0] opcode;
  assign opcode = instr[15:11];

  always_comb begin
    ctrl       = '0;
    ctrl.a     = rs;
    ctrl.b     = rt;
    ctrl.op    = instr;
    ctrl.sign  = 1'b1;
    if (opcode[4:2] == OP_SHIFTI_PFX) begin
      ctrl.b = {12'h000, instr[3:0]};
    end else begin
      case (opcode)
        OP_ADDI, OP_ST, OP_LD, OP_STU: ctrl.b = sext5(instr[4:0]);
        OP_SUBI: begin
          ctrl.b     = sext5(instr[4:0]);
          ctrl.inv_a = 1'b1;
          ctrl.cin   = 1'b1;
        end
        OP_XORI:  ctrl.b = {11'h000, instr[4:0]};
        OP_ANDNI: begin
          ctrl.b     = {11'h000, instr[4:0]};
          ctrl.inv_b = 1'b1;
        end
        OP_SLBI: begin
          ctrl.a = {rs[7:0], 8'h00};
          ctrl.b = {8'h00, instr[7:0]};
        end
        OP_RARITH: begin
          case (instr[1:0])
            FUNCT_SUB: begin
              ctrl.inv_a = 1'b1;
              ctrl.cin   = 1'b1;
            end
            FUNCT_ANDN: ctrl.inv_b = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds it in an output register until consumed.
// Define ALU_ISSUE_SKID_EN to add a skid entry and a registered in_ready.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  alu_ctrl_t dec;
  alu_ctrl_t out_q, out_d;
  logic      out_valid_q, out_valid_d;
  logic      accept, consume;

  alu_ctrl_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .instr (bus.in_instr),
    .rs    (bus.in_rs_data),
    .rt    (bus.in_rt_data),
    .ctrl  (dec)
  );

  assign accept  = bus.in_valid & bus.in_ready & ~bus.flush;
  assign consume = out_valid_q & bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  alu_ctrl_t skid_q, skid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      ready_q;

  assign bus.in_ready = ready_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (consume) out_valid_d = 1'b0;
      if (!out_valid_d) begin
        // The skid entry is older than anything arriving now, so it refills first.
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end
`else
  assign bus.in_ready = ~out_valid_q | bus.out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_a     = out_q.a;
  assign bus.alu_b     = out_q.b;
  assign bus.alu_op    = out_q.op;
  assign bus.alu_cin   = out_q.cin;
  assign bus.alu_inv_a = out_q.inv_a;
  assign bus.alu_inv_b = out_q.inv_b;
  assign bus.alu_sign  = out_q.sign;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors, backpressure, flush, reset and random traffic.
`timescale 1ns/1ps
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic armed = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue #(
    .DATA_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  alu_ctrl_t   exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic alu_ctrl_t bus_ctrl();
    alu_ctrl_t c;
    c.a     = bus.alu_a;
    c.b     = bus.alu_b;
    c.op    = bus.alu_op;
    c.cin   = bus.alu_cin;
    c.inv_a = bus.alu_inv_a;
    c.inv_b = bus.alu_inv_b;
    c.sign  = bus.alu_sign;
    return c;
  endfunction

  // Reference decode written straight from the opcode rules with integer arithmetic.
  function automatic alu_ctrl_t ref_ctrl(input logic [15:0] instr, input logic [15:0] rs,
                                         input logic [15:0] rt);
    alu_ctrl_t r;
    int op, s5, fn;
    op = int'(instr[15:11]);
    fn = int'(instr[1:0]);
    s5 = int'(instr[4:0]);
    if (s5 >= 16) s5 = s5 - 32;
    r.a = rs; r.b = rt; r.op = instr;
    r.cin = 1'b0; r.inv_a = 1'b0; r.inv_b = 1'b0; r.sign = 1'b1;
    if (op == 8 || op == 9 || op == 16 || op == 17 || op == 19) r.b = 16'(s5);
    if (op == 10 || op == 11) r.b = 16'(int'(instr[4:0]));
    if (op >= 20 && op <= 23) r.b = 16'(int'(instr[3:0]));
    if (op == 18) begin
      r.a = 16'(int'(rs) * 256);
      r.b = 16'(int'(instr[7:0]));
    end
    if (op == 9 || (op == 27 && fn == 1)) begin
      r.inv_a = 1'b1;
      r.cin   = 1'b1;
    end
    if (op == 11 || (op == 27 && fn == 3)) r.inv_b = 1'b1;
    return r;
  endfunction

  // How many entries the stage can hold, and when it may take one more.
  function automatic logic model_ready();
`ifdef ALU_ISSUE_SKID_EN
    return exp_q.size() < 2;
`else
    return exp_q.size() == 0 || bus.out_ready;
`endif
  endfunction

`ifdef ALU_ISSUE_SKID_EN
  localparam int unsigned Cap = 2;
`else
  localparam int unsigned Cap = 1;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Monitor: compare DUT against the head of the expected queue, then advance the model.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!armed) begin
      exp_q.delete();
    end else begin
      exp_rdy = model_ready();
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) check("issue", 64'(bus_ctrl()), 64'(exp_q[0]));
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (bus.in_valid && exp_rdy)
          exp_q.push_back(ref_ctrl(bus.in_instr, bus.in_rs_data, bus.in_rt_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [15:0] instr, input logic [15:0] rs, input logic [15:0] rt);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_rs_data = rs;
    bus.in_rt_data = rt;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] bp_instr [3];
  logic [15:0] got[$];
  logic [15:0] r_instr;
  int          idx;
  logic        rdy;

  initial begin
    bp_instr[0] = 16'h4101;
    bp_instr[1] = 16'h5102;
    bp_instr[2] = 16'hD803;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_rs_data = '0;
    bus.in_rt_data = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_fields", 64'(bus_ctrl()), 64'(0));
    #21 rst_n = 1'b1;
    step();
    step();
    check("ready_after_reset", 64'(bus.in_ready), 64'(1));

    // Directed decode vectors.
    issue_one(16'h4903, 16'h0005, 16'h0000);
    check("subi_valid", 64'(bus.out_valid), 64'(1));
    check("subi_a", 64'(bus.alu_a), 64'(16'h0005));
    check("subi_b", 64'(bus.alu_b), 64'(16'h0003));
    check("subi_ctl", 64'({bus.alu_inv_a, bus.alu_cin, bus.alu_inv_b}), 64'(3'b110));
    step();
    issue_one(16'h591F, 16'h1234, 16'h0000);
    check("andni_b", 64'(bus.alu_b), 64'(16'h001F));
    check("andni_ctl", 64'({bus.alu_inv_b, bus.alu_cin}), 64'(2'b10));
    step();
    issue_one(16'h91CD, 16'h00AB, 16'h0000);
    check("slbi_a", 64'(bus.alu_a), 64'(16'hAB00));
    check("slbi_b", 64'(bus.alu_b), 64'(16'h00CD));
    step();
    issue_one(16'hD941, 16'h0007, 16'h0009);
    check("rsub_ab", 64'({bus.alu_a, bus.alu_b}), 64'({16'h0007, 16'h0009}));
    check("rsub_ctl", 64'({bus.alu_inv_a, bus.alu_cin}), 64'(2'b11));
    step();

    // Backpressure: three back-to-back offers while the output is stalled.
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = bp_instr[idx];
      @(negedge clk);
      rdy = bus.in_ready;
      step();
      if (rdy) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(Cap));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (idx < 3);
      if (idx < 3) bus.in_instr = bp_instr[idx];
      @(negedge clk);
      rdy = bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.alu_op);
      step();
      if (bus.in_valid && rdy) idx++;
    end
    bus.in_valid = 1'b0;
    check("bp_count", 64'(got.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      check("bp_order", 64'((got.size() > i) ? got[i] : 16'hxxxx), 64'(bp_instr[i]));

    // Flush with the stage full and a new instruction on the input.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 16'h4000 + 16'(c);
      step();
    end
    bus.flush    = 1'b1;
    bus.in_instr = 16'h4A0A;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b1;
    step();
    issue_one(16'hD80E, 16'h1111, 16'h2222);
    check("flush_next_valid", 64'(bus.out_valid), 64'(1));
    check("flush_next_op", 64'(bus.alu_op), 64'(16'hD80E));
    step();

    // Random traffic with occasional flushes and one mid-run reset.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) begin
        bus.in_valid = 1'b1;
        bus.flush    = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("midreset_valid", 64'(bus.out_valid), 64'(0));
        check("midreset_fields", 64'(bus_ctrl()), 64'(0));
        bus.in_valid = 1'b0;
        step();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        step();
      end
      case ($urandom_range(0, 14))
        0:  r_instr = {OP_ADDI, 11'($urandom)};
        1:  r_instr = {OP_SUBI, 11'($urandom)};
        2:  r_instr = {OP_XORI, 11'($urandom)};
        3:  r_instr = {OP_ANDNI, 11'($urandom)};
        4:  r_instr = {OP_ST, 11'($urandom)};
        5:  r_instr = {OP_LD, 11'($urandom)};
        6:  r_instr = {OP_SLBI, 11'($urandom)};
        7:  r_instr = {OP_STU, 11'($urandom)};
        8:  r_instr = {OP_SHIFTI_PFX, 13'($urandom)};
        9:  r_instr = {OP_RSHIFT, 11'($urandom)};
        10, 11: r_instr = {OP_RARITH, 11'($urandom)};
        default: r_instr = 16'($urandom);
      endcase
      bus.in_instr   = r_instr;
      bus.in_rs_data = 16'($urandom);
      bus.in_rt_data = 16'($urandom);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = (cyc % 50 < 25) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DATA_W, 16, operand/result width; only 16 is supported.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  decode offers an instruction.
REQ-006 in_ready  output  1  block accepts the instruction this cycle.
REQ-007 in_instr  input  16  raw instruction word.
REQ-008 in_rs_data, in_rt_data  input  16 each  register-file read data.
REQ-009 flush  input  1  squash all held and incoming instructions.
REQ-010 out_valid  output  1  ALU operands/controls are valid.
REQ-011 out_ready  input  1  execute stage consumes the entry.
REQ-012 alu_a, alu_b, alu_op  output  16 each  ALU operand A, operand B, instruction word.
REQ-013 alu_cin, alu_inv_a, alu_inv_b, alu_sign  output  1 each  ALU controls.

Function
REQ-014 A transfer occurs when in_valid and in_ready are both high and flush is low; the output advances when out_valid and out_ready are both high.
REQ-015 Decode uses opcode in_instr[15:11]; alu_op is in_instr, unmodified.
REQ-016 Defaults: alu_a = rs, alu_b = imm or rt as below, cin = inv_a = inv_b = 0, sign = 1.
REQ-017 Opcode 01000 (ADDI): alu_b = sext(instr[4:0]).
REQ-018 Opcode 01001 (SUBI): alu_b = sext(instr[4:0]), inv_a = 1, cin = 1.
REQ-019 Opcodes 01010/01011 (XORI/ANDNI): alu_b = zext(instr[4:0]); ANDNI sets inv_b = 1.
REQ-020 Opcodes 101xx (shift immediates): alu_b = zext(instr[3:0]).
REQ-021 Opcodes 10000/10001/10011 (ST/LD/STU): alu_b = sext(instr[4:0]).
REQ-022 Opcode 10010 (SLBI): alu_a = rs << 8; alu_b = zext(instr[7:0]).
REQ-023 Opcodes 11010/11011 (R-format): alu_b = rt.
REQ-024 For 11011, funct instr[1:0] = 01 (SUB) sets inv_a = 1 and cin = 1; funct 11 (ANDN) sets inv_b = 1.
REQ-025 Any other opcode: alu_a = rs, alu_b = rt, defaults otherwise.
REQ-026 Issue latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N when the path is empty.
REQ-027 Outputs hold stable while out_valid = 1 and out_ready = 0.
REQ-028 Order is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-029 Flush is synchronous: all held entries are cleared and out_valid = 0 after the edge.
REQ-030 An input offered in the flush cycle is discarded.
REQ-031 Flush overrides a simultaneous accept and a simultaneous consume.

Reset
REQ-032 On rst_n low: out_valid = 0; alu_a, alu_b, alu_op = 0; all controls = 0; skid entry empty.
REQ-033 in_ready is 1 from the first edge after reset release.
REQ-034 Reset asserted mid-transfer discards all in-flight entries.

Configuration
REQ-035 Macro: ALU_ISSUE_SKID_EN.
REQ-036 With ALU_ISSUE_SKID_EN defined, a second skid entry is present and in_ready is registered: in_ready = !skid_full, with no combinational path from out_ready.
REQ-037 With the skid enabled, an input accepted while the output is stalled goes to the skid entry and moves to the output on the next consume.
REQ-038 With the skid enabled, sustained throughput is 1 per cycle.
REQ-039 Without ALU_ISSUE_SKID_EN there is a single output register, and in_ready = !out_valid | out_ready (combinational).

Structure
REQ-040 A shared package holds: opcode localparams (OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ST, OP_LD, OP_SLBI, OP_STU, OP_RSHIFT, OP_RARITH), R-format funct codes, and the packed struct alu_ctrl_t {a, b, op, cin, inv_a, inv_b, sign}.
REQ-041 One combinational sub-module, alu_ctrl_decode, maps instr, rs and rt to alu_ctrl_t; the top holds only the registers and the handshake.

Verification
REQ-042 SUBI: instr 0x4903, rs = 0x0005 -> next cycle alu_a = 0x0005, alu_b = 0x0003, inv_a = 1, cin = 1, inv_b = 0, out_valid = 1.
REQ-043 ANDNI: instr 0x591F, rs = 0x1234 -> alu_b = 0x001F (zero-extended), inv_b = 1, cin = 0.
REQ-044 SLBI: instr 0x91CD, rs = 0x00AB -> alu_a = 0xAB00, alu_b = 0x00CD.
REQ-045 R-format SUB: instr 0xD941, rs = 0x0007, rt = 0x0009 -> alu_a = 0x0007, alu_b = 0x0009, inv_a = 1, cin = 1.
REQ-046 Backpressure: out_ready = 0 for 3 cycles while 3 back-to-back valid inputs are offered.
REQ-047 With the skid enabled, 2 inputs are accepted, in_ready = 0 on the third, and releasing out_ready delivers all 3 in order.
REQ-048 Without the skid, only 1 input is accepted until out_ready rises.
REQ-049 Flush with both entries full and in_valid = 1 -> out_valid = 0 next cycle; the next accepted instruction is the first one issued.
